// File: rtl/display_pkg.sv
// Shared 7-segment display types and constants for the HEX drivers.
package display_pkg;

    localparam int unsigned SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t HEX_OFF = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        PAUSE  = 2'd2
    } scroll_state_t;

endpackage

// File: rtl/hex_scroll_window.sv
// Combinational sliding-window selector: maps a start position and message
// length onto NUM_DIGITS segment codes, wrapping within the message and blanking unused digits.
module scroll_window
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AW         = $clog2(DEPTH)
) (
    input  logic [AW-1:0]               pos_i,
    input  logic [AW:0]                 len_i,
    input  logic [DEPTH*SEG_W-1:0]      buf_i,
    output logic [NUM_DIGITS*SEG_W-1:0] win_o
);

    localparam int unsigned LW = AW + 1;

    logic [LW-1:0] sum;
    logic [LW-1:0] wrapped;
    logic [AW-1:0] idx;

    // pos+k never exceeds 2*DEPTH-2, so one conditional subtract of len is enough.
    always_comb begin
        win_o   = '0;
        sum     = '0;
        wrapped = '0;
        idx     = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            sum     = LW'(pos_i) + LW'(k);
            wrapped = (sum >= len_i) ? (sum - len_i) : sum;
            idx     = AW'(wrapped);
            if (LW'(k) >= len_i) begin
                win_o[k*SEG_W +: SEG_W] = HEX_OFF;
            end else begin
                win_o[k*SEG_W +: SEG_W] = buf_i[idx*SEG_W +: SEG_W];
            end
        end
    end

endmodule

// File: rtl/hex_scroll_driver.sv
// Scrolling multi-digit HEX driver: message buffer, scroll FSM and registered window output.
// Optional blink-while-paused behaviour is enabled with `define SCROLL_BLINK_EN.
module hex_scroll_driver
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        pause,
    input  logic                        dir,
    input  logic [AW:0]                 len,
    input  logic                        wr_en,
    input  logic [AW-1:0]               wr_addr,
    input  logic [SEG_W-1:0]            wr_data,
    output logic [NUM_DIGITS*SEG_W-1:0] hex_out,
    output logic [AW-1:0]               pos,
    output logic                        wrap,
    output logic                        busy
);

    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] ONE_L   = LW'(1);
    localparam logic [NUM_DIGITS*SEG_W-1:0] ALL_OFF = {NUM_DIGITS{HEX_OFF}};

    scroll_state_t             state_q, state_d;
    logic [AW-1:0]             pos_q, pos_d;
    logic [LW-1:0]             len_q, len_d;
    logic                      wrap_q, wrap_d;
    logic                      busy_q;
    logic [NUM_DIGITS*SEG_W-1:0] hex_q, hex_d;
    seg_t                      buf_q [DEPTH];
    logic [DEPTH*SEG_W-1:0]    buf_flat;
    logic [NUM_DIGITS*SEG_W-1:0] win;
    logic                      start_ok;
`ifdef SCROLL_BLINK_EN
    logic                      blink_q, blink_d;
`endif

    // Message buffer; writes are accepted in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= HEX_OFF;
            end
        end else if (wr_en) begin
            buf_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        buf_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            buf_flat[i*SEG_W +: SEG_W] = buf_q[i];
        end
    end

    // Window is evaluated on the next-state pos/len so hex_out tracks pos with no lag.
    scroll_window #(
        .NUM_DIGITS (NUM_DIGITS),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_window (
        .pos_i (pos_d),
        .len_i (len_d),
        .buf_i (buf_flat),
        .win_o (win)
    );

    assign start_ok = start && (len != '0) && (len <= DEPTH_L);

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        len_d   = len_q;
        wrap_d  = 1'b0;
        hex_d   = ALL_OFF;
`ifdef SCROLL_BLINK_EN
        blink_d = 1'b0;
`endif
        if (stop) begin
            state_d = IDLE;
        end else if (start && (start_ok || state_q != IDLE)) begin
            state_d = SCROLL;
            pos_d   = '0;
            if (start_ok) begin
                len_d = len;
            end
        end else begin
            case (state_q)
                SCROLL: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (en) begin
                        if (!dir) begin
                            if (LW'(pos_q) == (len_q - ONE_L)) begin
                                pos_d  = '0;
                                wrap_d = 1'b1;
                            end else begin
                                pos_d = pos_q + AW'(1);
                            end
                        end else begin
                            if (pos_q == '0) begin
                                pos_d  = AW'(len_q - ONE_L);
                                wrap_d = 1'b1;
                            end else begin
                                pos_d = pos_q - AW'(1);
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (!pause) begin
                        state_d = SCROLL;
                    end
                end
                default: ;
            endcase
        end

`ifdef SCROLL_BLINK_EN
        if (state_d == PAUSE) begin
            blink_d = blink_q ^ ((state_q == PAUSE) && en);
        end
`endif

        if (state_d != IDLE) begin
            hex_d = win;
`ifdef SCROLL_BLINK_EN
            if (blink_d) begin
                hex_d = ALL_OFF;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pos_q   <= '0;
            len_q   <= '0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
            hex_q   <= ALL_OFF;
`ifdef SCROLL_BLINK_EN
            blink_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            len_q   <= len_d;
            wrap_q  <= wrap_d;
            busy_q  <= (state_d != IDLE);
            hex_q   <= hex_d;
`ifdef SCROLL_BLINK_EN
            blink_q <= blink_d;
`endif
        end
    end

    assign hex_out = hex_q;
    assign pos     = pos_q;
    assign wrap    = wrap_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_hex_scroll_driver.sv
// Directed scoreboard bench for hex_scroll_driver (NUM_DIGITS=6, DEPTH=16).
module tb_hex_scroll_driver;

    localparam logic [41:0] OFF = {6{7'h7F}};

    logic        clk;
    logic        reset;
    logic        en;
    logic        start;
    logic        stop;
    logic        pause;
    logic        dir;
    logic [4:0]  len;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [6:0]  wr_data;
    logic [41:0] hex_out;
    logic [3:0]  pos;
    logic        wrap;
    logic        busy;

    typedef struct packed {
        logic [41:0] hex;
        logic [3:0]  pos;
        logic        wrap;
        logic        busy;
    } exp_t;

    exp_t        sb_q [$];
    string       tag_q [$];
    logic [6:0]  mb [16];
    logic [6:0]  seg_tab [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    int          tests = 0;
    int          fails = 0;
    int          p;
    logic [41:0] h;

    hex_scroll_driver #(.NUM_DIGITS(6), .DEPTH(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .dir     (dir),
        .len     (len),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .hex_out (hex_out),
        .pos     (pos),
        .wrap    (wrap),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected window from the bench's own copy of the message buffer.
    function automatic logic [41:0] win(input int wp, input int wl);
        logic [41:0] r;
        int idx;
        r = '0;
        for (int k = 0; k < 6; k++) begin
            if (k >= wl) begin
                r[k*7 +: 7] = 7'h7F;
            end else begin
                idx = wp + k;
                if (idx >= wl) idx = idx - wl;
                r[k*7 +: 7] = mb[idx];
            end
        end
        return r;
    endfunction

    task automatic check_out();
        exp_t  e;
        string t;
        if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_empty: got 0 entries, need 1");
            return;
        end
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        tests++;
        assert (hex_out === e.hex) else begin
            fails++;
            $error("FAIL %s hex_out: got %h exp %h", t, hex_out, e.hex);
        end
        tests++;
        assert (pos === e.pos) else begin
            fails++;
            $error("FAIL %s pos: got %0d exp %0d", t, pos, e.pos);
        end
        tests++;
        assert (wrap === e.wrap) else begin
            fails++;
            $error("FAIL %s wrap: got %b exp %b", t, wrap, e.wrap);
        end
        tests++;
        assert (busy === e.busy) else begin
            fails++;
            $error("FAIL %s busy: got %b exp %b", t, busy, e.busy);
        end
    endtask

    // Push the expectation for the coming edge, clock once, then compare.
    task automatic cyc(input string t, input int ep, input logic ew, input logic eb,
                       input logic [41:0] eh);
        exp_t e;
        e.hex  = eh;
        e.pos  = 4'(ep);
        e.wrap = ew;
        e.busy = eb;
        sb_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        dir = 1'b0; len = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < 16; i++) mb[i] = 7'h7F;

        cyc("reset", 0, 1'b0, 1'b0, OFF);
        reset = 1'b0;
        cyc("idle", 0, 1'b0, 1'b0, OFF);

        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = seg_tab[i];
            cyc("write_idle", 0, 1'b0, 1'b0, OFF);
            mb[i] = seg_tab[i];
        end
        wr_en = 1'b0;

        start = 1'b1; len = 5'd8; dir = 1'b0;
        cyc("start8", 0, 1'b0, 1'b1, win(0, 8));
        start = 1'b0;
        en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            p = i % 8;
            cyc("step_left", p, (i == 8), 1'b1, win(p, 8));
        end
        en = 1'b0;
        cyc("no_tick", 0, 1'b0, 1'b1, win(0, 8));

        start = 1'b1; len = 5'd3;
        cyc("start3", 0, 1'b0, 1'b1, win(0, 3));
        start = 1'b0;
        dir = 1'b1; en = 1'b1;
        cyc("right_wrap", 2, 1'b1, 1'b1, win(2, 3));
        cyc("right_step", 1, 1'b0, 1'b1, win(1, 3));
        en = 1'b0;

        pause = 1'b1;
        cyc("pause_enter", 1, 1'b0, 1'b1, win(1, 3));
        en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            h = win(1, 3);
`ifdef SCROLL_BLINK_EN
            if (i % 2 == 1) h = OFF;
`endif
            cyc("pause_tick", 1, 1'b0, 1'b1, h);
        end
        en = 1'b0; pause = 1'b0;
        cyc("pause_exit", 1, 1'b0, 1'b1, win(1, 3));
        en = 1'b1;
        cyc("resume_step", 0, 1'b0, 1'b1, win(0, 3));
        cyc("right_wrap2", 2, 1'b1, 1'b1, win(2, 3));
        en = 1'b0;

        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 7'h40;
        cyc("write_lag", 2, 1'b0, 1'b1, win(2, 3));
        wr_en = 1'b0;
        mb[2] = 7'h40;
        cyc("write_show", 2, 1'b0, 1'b1, win(2, 3));

        en = 1'b1; wr_en = 1'b1; wr_addr = 4'd1; wr_data = 7'h7E;
        cyc("step_write_old", 1, 1'b0, 1'b1, win(1, 3));
        en = 1'b0; wr_en = 1'b0;
        mb[1] = 7'h7E;
        cyc("step_write_new", 1, 1'b0, 1'b1, win(1, 3));

        stop = 1'b1; en = 1'b1;
        cyc("stop_with_en", 1, 1'b0, 1'b0, OFF);
        stop = 1'b0; en = 1'b0;

        start = 1'b1; len = 5'd0;
        cyc("start_len0", 1, 1'b0, 1'b0, OFF);
        len = 5'd17;
        cyc("start_len17", 1, 1'b0, 1'b0, OFF);
        len = 5'd16;
        cyc("start16", 0, 1'b0, 1'b1, win(0, 16));
        start = 1'b0;
        en = 1'b1; dir = 1'b1;
        cyc("wrap16_right", 15, 1'b1, 1'b1, win(15, 16));
        dir = 1'b0;
        cyc("wrap16_left", 0, 1'b1, 1'b1, win(0, 16));
        en = 1'b0;

        start = 1'b1; len = 5'd1;
        cyc("start1", 0, 1'b0, 1'b1, win(0, 1));
        start = 1'b0; en = 1'b1;
        cyc("len1_left", 0, 1'b1, 1'b1, win(0, 1));
        dir = 1'b1;
        cyc("len1_right", 0, 1'b1, 1'b1, win(0, 1));

        reset = 1'b1;
        cyc("reset_mid", 0, 1'b0, 1'b0, OFF);
        reset = 1'b0; en = 1'b0; dir = 1'b0;
        for (int i = 0; i < 16; i++) mb[i] = 7'h7F;
        start = 1'b1; len = 5'd8;
        cyc("buf_cleared", 0, 1'b0, 1'b1, win(0, 8));
        start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hex_scroll_driver.md
Name: hex_scroll_driver

Overview:
Parametrised successor to the single-digit HEX driver. Holds a writable message buffer of 7-segment codes and drives NUM_DIGITS HEX displays as a sliding window over that buffer. The window advances one position per enable tick, left or right, with wrap-around. It sits between the message-loading logic and the HEX pins; the enable tick comes from the shared clock divider.

Parameters:
NUM_DIGITS, 6, number of HEX digits driven; 1..DEPTH.
DEPTH, 16, message buffer entries; power of two, >= NUM_DIGITS.
AW, $clog2(DEPTH), buffer address width (derived; do not override).

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
en  in  1  scroll tick; one-cycle strobe, advances the window once.
start  in  1  pulse; latches len and begins scrolling from position 0.
stop  in  1  pulse; returns to IDLE and blanks all digits.
pause  in  1  level; freezes the window while high.
dir  in  1  0 = scroll left (pos+1), 1 = scroll right (pos-1).
len  in  AW+1  message length in entries, sampled on start.
wr_en  in  1  buffer write strobe.
wr_addr  in  AW  buffer write address.
wr_data  in  7  segment code to write (active-low segments).
hex_out  out  NUM_DIGITS*7  digit k occupies bits [7k+6:7k]; k=0 is the leftmost digit.
pos  out  AW  current window start index.
wrap  out  1  one-cycle pulse when pos wraps.
busy  out  1  high in SCROLL or PAUSE.

Behaviour:
- Reset: every buffer entry = HEX_OFF (7'h7F), hex_out = all HEX_OFF, pos = 0, wrap = 0, busy = 0, len_q = 0, state = IDLE.
- States: IDLE, SCROLL, PAUSE.
  - IDLE -> SCROLL on start with 1 <= len <= DEPTH. Sets len_q = len and pos = 0.
  - A start with len = 0 or len > DEPTH is ignored.
  - SCROLL -> PAUSE while pause = 1; PAUSE -> SCROLL when pause = 0.
  - SCROLL or PAUSE -> IDLE on stop. stop takes priority over start, pause and en.
  - start while in SCROLL or PAUSE restarts: re-latches len (if valid) and sets pos = 0.
- Step (SCROLL and en = 1 only):
  - dir = 0: pos = (pos == len_q-1) ? 0 : pos+1.
  - dir = 1: pos = (pos == 0) ? len_q-1 : pos-1.
  - wrap pulses in the same cycle that pos takes the wrapped value.
  - When len_q = 1, pos stays 0 and wrap pulses on every step.
  - en is ignored in IDLE and PAUSE.
- Window:
  - Digit k shows buf[idx], with idx = pos+k, minus len_q if pos+k >= len_q.
  - Digits with k >= len_q show HEX_OFF; there is no repeat within one window.
- hex_out is registered.
  - In SCROLL or PAUSE it is reloaded every cycle from the next-state pos and the current buffer.
  - After a step edge, hex_out already reflects the new pos (0-cycle lag relative to pos).
  - In IDLE, hex_out = all HEX_OFF.
- Writes:
  - Accepted in any state.
  - A write landing at edge t is visible on hex_out at edge t+1.
  - A write to an entry >= len_q is stored but not displayed until a later start.
- Simultaneous step and write to a displayed entry: the step uses the old data; the new data appears on the following cycle.
- Reset mid-operation: immediate return to reset values, including buffer contents.

Optional Feature:
SCROLL_BLINK_EN:
- Defined: in PAUSE, each en tick toggles a blink flag. While the flag is set, hex_out = all HEX_OFF.
- The flag clears on leaving PAUSE, so display is restored in the first SCROLL cycle.
- Undefined: PAUSE holds hex_out static, and en has no effect in PAUSE.

Decomposition:
- Shared package display_pkg:
  - SEG_W = 7.
  - HEX_OFF = 7'h7F.
  - typedef enum logic[1:0] scroll_state_t {IDLE, SCROLL, PAUSE}.
  - typedef logic[SEG_W-1:0] seg_t.
- One sub-module, scroll_window: combinational.
  - Inputs: pos, len_q, flattened buffer.
  - Output: the NUM_DIGITS-digit window, with the index wrap and blanking of digits k >= len_q.
- Keep the state machine, pos counter and buffer in the top level.

Test Plan:
- Reset, then no activity -> hex_out = 42'h3FF_FFFF_FFFF (all 7'h7F), pos = 0, busy = 0.
- Write buf[0..7] = codes for 0..7; start with len = 8, dir = 0; 8 en ticks -> pos goes 1..7,0; wrap pulses once on the 8th tick; digit 0 follows 1,2,...,7,0.
- len = 3, NUM_DIGITS = 6, start -> digits 0..2 = buf[0..2], digits 3..5 = 7'h7F; dir = 1 with one tick -> pos = 2, wrap = 1, digits = buf[2],buf[0],buf[1].
- Hold pause = 1 over 3 en ticks -> pos unchanged and busy = 1. With SCROLL_BLINK_EN the display alternates blank/shown/blank; drop pause -> display restored.
- Same-cycle stop and en in SCROLL -> state IDLE, pos unchanged, hex_out all 7'h7F next cycle. Start with len = 0 or len = 17 -> stays IDLE.
- While scrolling, write buf[pos] = 7'h40 -> digit 0 shows 7'h40 one cycle later. Assert reset mid-scroll -> all outputs and buffer return to reset values.
